// File: rtl/riscv_pipeline_core_pkg.sv
// Shared encodings for the 5-stage RV32I-subset core: opcodes, funct fields,
// ALU operations and the per-instruction control bundle carried down the pipe.
package riscv_pipeline_core_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_e;

    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    mem_re;
        logic    branch;
        logic    bne;
        logic    use_imm;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{reg_we: 1'b0, mem_we: 1'b0, mem_re: 1'b0, branch: 1'b0,
                                   bne: 1'b0, use_imm: 1'b0, alu_op: ALU_ADD};

endpackage

// File: rtl/riscv_pipeline_core_units.sv
// Storage units of the core: 2R/1W register file with write-through reads,
// and word-addressed data RAM with synchronous write and combinational read.
module reg_file
    import riscv_pipeline_core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data
);
    logic [XLEN-1:0] registers [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && rd_addr != 5'd0) begin
            registers[rd_addr] <= rd_data;
        end
    end

    // WB writes are visible to ID in the same cycle, covering the WB->ID hazard.
    always_comb begin
        rs1_data = registers[rs1_addr];
        rs2_data = registers[rs2_addr];
        if (we && rd_addr == rs1_addr) rs1_data = rd_data;
        if (we && rd_addr == rs2_addr) rs2_data = rd_data;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end
endmodule

module data_mem
    import riscv_pipeline_core_pkg::*;
#(
    parameter int DMEM_DEPTH = 64,
    parameter int DAW        = $clog2(DMEM_DEPTH)
) (
    input  logic            clk,
    input  logic [DAW-1:0]  addr,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);
    logic [XLEN-1:0] memory [0:DMEM_DEPTH-1] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
    end

    always_comb rdata = memory[addr];
endmodule

// File: rtl/riscv_pipeline_core.sv
// Five-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB), no forwarding or
// interlocks; branches resolve in EX and flush the two younger instructions.
module riscv_pipeline_core
    import riscv_pipeline_core_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input logic clk,
    input logic rst_n
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    function automatic logic [XLEN-1:0] rom_word(input logic [IAW-1:0] idx);
        case (int'(idx))
            0:       rom_word = 32'h0640_0513; // addi x10,x0,100
            1:       rom_word = 32'h0140_0593; // addi x11,x0,20
            4:       rom_word = 32'h00B5_0633; // add  x12,x10,x11
            5:       rom_word = 32'h40B5_06B3; // sub  x13,x10,x11
            8:       rom_word = 32'h00C0_2223; // sw   x12,4(x0)
            9:       rom_word = 32'h00D0_2423; // sw   x13,8(x0)
            10:      rom_word = 32'h0040_2703; // lw   x14,4(x0)
            11:      rom_word = 32'h0080_2783; // lw   x15,8(x0)
            14:      rom_word = 32'h00C7_0463; // beq  x14,x12,+8
            15:      rom_word = 32'h0630_0813; // addi x16,x0,99
            16:      rom_word = 32'h0010_0813; // addi x16,x0,1
            default: rom_word = NOP_INSTR;
        endcase
    endfunction

    logic [XLEN-1:0] pc, ifid_instr, ifid_pc;
    ctrl_t           id_ctrl, idex_ctrl;
    logic [XLEN-1:0] id_imm, id_rs1, id_rs2;
    logic [XLEN-1:0] idex_pc, idex_rs1, idex_rs2, idex_imm;
    logic [4:0]      idex_rd, exmem_rd, memwb_rd;
    logic [XLEN-1:0] alu_b, alu_y;
    logic            take_branch;
    logic            exmem_reg_we, exmem_mem_we, exmem_mem_re, memwb_reg_we;
    logic [XLEN-1:0] exmem_alu, exmem_store, dmem_rdata, memwb_data;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    always_comb begin
        opcode = ifid_instr[6:0];
        funct3 = ifid_instr[14:12];
        funct7 = ifid_instr[31:25];
    end

    always_comb begin
        id_ctrl = CTRL_NOP;
        id_imm  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
        case (opcode)
            OP_R, OP_I: begin
                id_ctrl.reg_we  = 1'b1;
                id_ctrl.use_imm = (opcode == OP_I);
                case (funct3)
                    F3_ADD:  id_ctrl.alu_op = (opcode == OP_R && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  id_ctrl.alu_op = ALU_SLL;
                    F3_SLT:  id_ctrl.alu_op = ALU_SLT;
                    F3_SLTU: id_ctrl.alu_op = ALU_SLTU;
                    F3_XOR:  id_ctrl.alu_op = ALU_XOR;
                    F3_SR:   id_ctrl.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    F3_OR:   id_ctrl.alu_op = ALU_OR;
                    default: id_ctrl.alu_op = ALU_AND;
                endcase
            end
            OP_LUI: begin
                id_ctrl.reg_we  = 1'b1;
                id_ctrl.use_imm = 1'b1;
                id_ctrl.alu_op  = ALU_LUI;
                id_imm          = {ifid_instr[31:12], 12'b0};
            end
            OP_LOAD: if (funct3 == F3_WORD) begin
                id_ctrl.reg_we  = 1'b1;
                id_ctrl.mem_re  = 1'b1;
                id_ctrl.use_imm = 1'b1;
            end
            OP_STORE: if (funct3 == F3_WORD) begin
                id_ctrl.mem_we  = 1'b1;
                id_ctrl.use_imm = 1'b1;
                id_imm          = {{20{ifid_instr[31]}}, funct7, ifid_instr[11:7]};
            end
            OP_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                id_ctrl.branch = 1'b1;
                id_ctrl.bne    = (funct3 == F3_BNE);
                id_imm         = {{20{ifid_instr[31]}}, ifid_instr[7], ifid_instr[30:25],
                                  ifid_instr[11:8], 1'b0};
            end
            default: id_ctrl = CTRL_NOP;
        endcase
    end

    reg_file reg_file_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (ifid_instr[19:15]),
        .rs2_addr (ifid_instr[24:20]),
        .rs1_data (id_rs1),
        .rs2_data (id_rs2),
        .we       (memwb_reg_we),
        .rd_addr  (memwb_rd),
        .rd_data  (memwb_data)
    );

    always_comb begin
        alu_b = idex_ctrl.use_imm ? idex_imm : idex_rs2;
        case (idex_ctrl.alu_op)
            ALU_SUB:  alu_y = idex_rs1 - alu_b;
            ALU_AND:  alu_y = idex_rs1 & alu_b;
            ALU_OR:   alu_y = idex_rs1 | alu_b;
            ALU_XOR:  alu_y = idex_rs1 ^ alu_b;
            ALU_SLL:  alu_y = idex_rs1 << alu_b[4:0];
            ALU_SRL:  alu_y = idex_rs1 >> alu_b[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(idex_rs1) >>> alu_b[4:0]);
            ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(idex_rs1) < $signed(alu_b)};
            ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, idex_rs1 < alu_b};
            ALU_LUI:  alu_y = alu_b;
            default:  alu_y = idex_rs1 + alu_b;
        endcase
        take_branch = idex_ctrl.branch && ((idex_rs1 == idex_rs2) != idex_ctrl.bne);
    end

    data_mem #(.DMEM_DEPTH(DMEM_DEPTH)) data_mem_inst (
        .clk   (clk),
        .addr  (exmem_alu[DAW+1:2]),
        .we    (exmem_mem_we),
        .wdata (exmem_store),
        .rdata (dmem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= '0;
            ifid_instr   <= NOP_INSTR;
            ifid_pc      <= '0;
            idex_ctrl    <= CTRL_NOP;
            idex_pc      <= '0;
            idex_rs1     <= '0;
            idex_rs2     <= '0;
            idex_imm     <= '0;
            idex_rd      <= '0;
            exmem_reg_we <= 1'b0;
            exmem_mem_we <= 1'b0;
            exmem_mem_re <= 1'b0;
            exmem_alu    <= '0;
            exmem_store  <= '0;
            exmem_rd     <= '0;
            memwb_reg_we <= 1'b0;
            memwb_rd     <= '0;
            memwb_data   <= '0;
        end else begin
            pc         <= take_branch ? idex_pc + idex_imm : pc + 32'd4;
            ifid_instr <= take_branch ? NOP_INSTR : rom_word(pc[IAW+1:2]);
            ifid_pc    <= pc;
            idex_ctrl  <= take_branch ? CTRL_NOP : id_ctrl;
            idex_pc    <= ifid_pc;
            idex_rs1   <= id_rs1;
            idex_rs2   <= id_rs2;
            idex_imm   <= id_imm;
            idex_rd    <= ifid_instr[11:7];
            exmem_reg_we <= idex_ctrl.reg_we;
            exmem_mem_we <= idex_ctrl.mem_we;
            exmem_mem_re <= idex_ctrl.mem_re;
            exmem_alu    <= alu_y;
            exmem_store  <= idex_rs2;
            exmem_rd     <= idex_rd;
            memwb_reg_we <= exmem_reg_we;
            memwb_rd     <= exmem_rd;
            memwb_data   <= exmem_mem_re ? dmem_rdata : exmem_alu;
        end
    end
endmodule

// File: tb/tb_riscv_pipeline_core.sv
// Directed bench for riscv_pipeline_core: runs the built-in program from reset,
// checks register/memory results, latency, the branch flush and mid-run reset.
module tb_riscv_pipeline_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   saw99 = 1'b0;

    always #5 clk = ~clk;

    riscv_pipeline_core #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // The flushed addi at 0x3C would leave 99 in x16 for at least one cycle.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (dut.reg_file_inst.registers[16] === 32'd99) saw99 = 1'b1;
        end
    endtask

    function automatic logic [31:0] regs_or();
        logic [31:0] acc = '0;
        for (int i = 0; i < 32; i++) acc |= dut.reg_file_inst.registers[i];
        return acc;
    endfunction

    task automatic check_final(input string p);
        check({p, "_x10"}, dut.reg_file_inst.registers[10], 32'd100);
        check({p, "_x11"}, dut.reg_file_inst.registers[11], 32'd20);
        check({p, "_x12"}, dut.reg_file_inst.registers[12], 32'd120);
        check({p, "_x13"}, dut.reg_file_inst.registers[13], 32'd80);
        check({p, "_x14"}, dut.reg_file_inst.registers[14], 32'd120);
        check({p, "_x15"}, dut.reg_file_inst.registers[15], 32'd80);
        check({p, "_x0"},  dut.reg_file_inst.registers[0],  32'd0);
        check({p, "_mem1"}, dut.data_mem_inst.memory[1], 32'd120);
        check({p, "_mem2"}, dut.data_mem_inst.memory[2], 32'd80);
        check({p, "_mem0"}, dut.data_mem_inst.memory[0], 32'd0);
        check({p, "_mem3"}, dut.data_mem_inst.memory[3], 32'd0);
        check({p, "_no_flushed_write"}, {31'd0, saw99}, 32'd0);
    endtask

    initial begin
        // Power-on reset for 2 cycles.
        repeat (2) @(posedge clk);
        #1;
        check("rst_regs_zero", regs_or(), 32'd0);
        check("rst_x0", dut.reg_file_inst.registers[0], 32'd0);
        check("rst_mem1_init", dut.data_mem_inst.memory[1], 32'd0);

        @(negedge clk) rst_n = 1'b1;
        run(4);
        check("lat_x10_edge4", dut.reg_file_inst.registers[10], 32'd0);
        run(1);
        check("lat_x10_edge5", dut.reg_file_inst.registers[10], 32'd100);
        run(16);
        check("lat_x16_edge21", dut.reg_file_inst.registers[16], 32'd0);
        run(1);
        check("lat_x16_edge22", dut.reg_file_inst.registers[16], 32'd1);
        run(3);
        check_final("run1");
        check("run1_x16", dut.reg_file_inst.registers[16], 32'd1);

        // Reset again, release, and interrupt the program at cycle 8.
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("rst2_regs_zero", regs_or(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst2_x0", dut.reg_file_inst.registers[0], 32'd0);
        @(negedge clk) rst_n = 1'b1;
        saw99 = 1'b0;
        run(8);
        check("mid_x10", dut.reg_file_inst.registers[10], 32'd100);
        check("mid_x12_pending", dut.reg_file_inst.registers[12], 32'd0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_regs_zero", regs_or(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_hold_zero", regs_or(), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run(25);
        check_final("run2");
        check("run2_x16", dut.reg_file_inst.registers[16], 32'd1);

        // Program tail is NOPs: nothing changes afterwards.
        run(10);
        check("idle_x16", dut.reg_file_inst.registers[16], 32'd1);
        check("idle_x12", dut.reg_file_inst.registers[12], 32'd120);
        check("idle_mem1", dut.data_mem_inst.memory[1], 32'd120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_pipeline_core.md
RISCV_PIPELINE_CORE -- requirements
Module: riscv_pipeline_core

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, instruction ROM depth in 32-bit words.
REQ-002 Parameter DMEM_DEPTH, default 64, data RAM depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 No other ports; results are read hierarchically: reg_file_inst.registers[0:31] and data_mem_inst.memory[0:DMEM_DEPTH-1], both 32-bit.

Function
REQ-006 Classic 5-stage in-order pipeline: IF, ID, EX, MEM, WB, with registers IF/ID, ID/EX, EX/MEM and MEM/WB; one instruction issued per cycle, no stalls.
REQ-007 No data forwarding and no load-use interlock; software guarantees the hazard spacing.
REQ-008 Register file: 2 combinational read ports and 1 write port in WB; same-cycle write/read of the same register returns the new value; x0 reads 0 and ignores writes.
REQ-009 Instruction set: R-type ADD SUB AND OR XOR SLL SRL SRA SLT SLTU; I-type ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI; LUI; LW; SW; BEQ; BNE.
REQ-010 Unsupported opcodes execute as NOP: no register write and no memory write.
REQ-011 Arithmetic is 32-bit two's complement with wrap-around; immediates are sign-extended; shift amount is the low 5 bits.
REQ-012 LW and SW are word-only; effective address = rs1 + imm; word index = addr[log2(DMEM_DEPTH)+1:2]; the low 2 address bits are ignored.
REQ-013 Data memory write is synchronous in MEM; the read is combinational in MEM.
REQ-014 Branches are resolved in EX with target = PC + B-imm.
REQ-015 When a branch is taken, the PC is redirected on the next edge and the two younger instructions in IF/ID and ID/EX are flushed to bubbles.
REQ-016 PC starts at 0 and increments by 4 per cycle.
REQ-017 The instruction ROM is indexed by PC[log2(IMEM_DEPTH)+1:2].
REQ-018 Instruction ROM is initialised with the program below; all unlisted words are 0x00000013 (NOP).
  0x00 addi x10,x0,100 | 0x04 addi x11,x0,20 | 0x08,0x0C nop
  0x10 add x12,x10,x11 | 0x14 sub x13,x10,x11 | 0x18,0x1C nop
  0x20 sw x12,4(x0) | 0x24 sw x13,8(x0) | 0x28 lw x14,4(x0) | 0x2C lw x15,8(x0)
  0x30,0x34 nop | 0x38 beq x14,x12,+8 | 0x3C addi x16,x0,99 | 0x40 addi x16,x0,1
REQ-019 Architectural results are complete no later than 22 rising edges after rst_n deasserts.
REQ-020 After the program, the core executes NOPs indefinitely, with no state change.

Reset
REQ-021 While rst_n is low: PC=0, all pipeline registers hold bubbles (NOP, write enables low), and all 32 registers are 0.
REQ-022 Deassertion takes effect at the next clock; the first fetch is from 0x00.
REQ-023 Data memory is not reset; it is zero-initialised at time 0.

Structure
REQ-024 Package defines holds: opcode constants, funct3/funct7 constants, ALU-operation enum, NOP encoding, and XLEN=32.
REQ-025 Sub-module reg_file, instanced as reg_file_inst, with array registers.
REQ-026 Sub-module data_mem, instanced as data_mem_inst, with array memory.
REQ-027 Instruction ROM, decode, immediate generation, ALU and pipeline registers are inline in the core.

Verification
REQ-028 Reset 2 cycles, run 25 cycles -> x10=100, x11=20, x12=120, x13=80.
REQ-029 Same run -> memory[1]=120, memory[2]=80, x14=120, x15=80.
REQ-030 Same run -> x16=1, proving the taken branch flushed the addi at 0x3C.
REQ-031 Assert rst_n mid-program (cycle 8), release, run 25 cycles -> same final values as REQ-028 and REQ-029; registers read 0 while in reset.
REQ-032 During reset -> x0=0 at all times; no memory write occurs while any stage holds a bubble.
REQ-033 Replace the beq at 0x38 with bne -> branch not taken; x16=1 after 0x3C then 0x40 retire in order, with no flush.
